mult_sequencer: RTL
===================

// Module: mult_sequencer
// PURPOSE
//   Cycle sequencer for the 8-bit signed shift-add multiplier datapath (A/B shift registers, X sign flop, 9-bit adder).
//   Converts the Run key and the Reset_Load_Clear key into one-cycle Clr_Ld/ClrA/Add/Sub/Shift strobes.
//   Gives a fixed-latency multiply with Busy/Done status.
//   Sits between the top-level key inputs and the datapath; replaces ad-hoc control wiring in the multiplier top.
// PARAMETERS
//   WIDTH        8   operand width; number of add/shift iterations
//   SYNC_STAGES  2   flops in Run/Reset_Load_Clear synchronizers (>=2)
// PORTS
//   Clk               in   1  system clock, all state on rising edge
//   Reset_n           in   1  asynchronous, active-low reset
//   Run               in   1  level request to start a multiply (raw key, async)
//   Reset_Load_Clear  in   1  level request to load B from SW and clear A/X (raw key, async)
//   M                 in   1  current multiplier LSB (Bval[0]) from datapath
//   Clr_Ld            out  1  datapath: load B, clear A and X (one cycle)
//   ClrA              out  1  datapath: clear A and X only, B kept (one cycle)
//   Add               out  1  datapath: A/X <= A + SW (sign-extended)
//   Sub               out  1  datapath: A/X <= A - SW (sign-extended)
//   Shift             out  1  datapath: arithmetic right shift of X:A:B
//   Busy              out  1  multiply in progress
//   Done              out  1  result valid in A:B; held until Run released
// BEHAVIOUR
//   Reset (Reset_n=0, async): state=IDLE, count=0, synchronizers cleared, all outputs 0.
//   Inputs Run and Reset_Load_Clear pass through SYNC_STAGES flops before use (runs, rlc below).
//   States: IDLE, CLRA, ADD, SHIFT, HOLD.
//   IDLE:  rlc=1 -> Clr_Ld=1 in every IDLE cycle rlc is high, stay IDLE.
//          runs=1 (and rlc=0) -> CLRA; rlc has priority when both high.
//   CLRA:  ClrA=1 for exactly one cycle, count<=0 -> ADD.
//   ADD:   M=1 and count<WIDTH-1 -> Add=1.
//          M=1 and count==WIDTH-1 -> Sub=1 (two's-complement sign bit).
//          M=0 -> no strobe; the cycle is still consumed.
//          -> SHIFT.
//   SHIFT: Shift=1; count<=count+1; if count==WIDTH-1 -> HOLD else -> ADD.
//   HOLD:  Done=1; runs=0 -> IDLE; rlc ignored until IDLE.
//   Busy=1 in CLRA, ADD, SHIFT.
//   Latency: Busy high exactly 1+2*WIDTH cycles (17 for WIDTH=8); Done rises the cycle after the last Shift.
//   Strobe exclusivity: at most one of Clr_Ld, ClrA, Add, Sub, Shift high in any cycle.
//   count is $clog2(WIDTH)+1 bits wide; it never wraps, it is reset to 0 in CLRA.
//   Run held high across the end of a multiply does not restart the sequencer; a new multiply needs Run low, then high.
//   Run dropping mid-multiply: ignored, sequence completes, HOLD exits next cycle.
//   Reset_Load_Clear mid-multiply: ignored, no Clr_Ld while Busy or Done.
//   Reset_n asserted mid-multiply: all strobes drop immediately (async); datapath contents are undefined to the sequencer.
//   All outputs are Moore (decoded from state/count), except Add/Sub, which also depend on registered-path M.
// STRUCTURE
//   Package mult_pkg: typedef enum logic [2:0] mult_state_t {IDLE,CLRA,ADD,SHIFT,HOLD};
//     localparam MULT_WIDTH=8 shared with datapath top.
//   Sub-module sync_ff #(SYNC_STAGES) instantiated twice (Run, Reset_Load_Clear); async active-low clear.
//   Remainder: one always_ff (state, count), one always_comb (next state, strobes).
// TESTING
//   1. Reset_n=0 mid-ADD -> all outputs 0 same cycle; after release, state IDLE, Busy=0, Done=0.
//   2. Reset_Load_Clear pulse 3 cycles in IDLE -> Clr_Ld high 3 cycles (after sync delay), no other strobe.
//   3. Run=1, M tied 1 -> ClrA x1, then Add/Shift alternating 7 times, then Sub,Shift; Busy 17 cycles; Done=1.
//   4. Run=1, M tied 0 -> zero Add/Sub pulses, 8 Shift pulses, Busy still 17 cycles.
//   5. Run held high 40 cycles -> exactly one multiply, Done held; Run low -> IDLE; Run high again -> second ClrA.
//   6. Run and Reset_Load_Clear both high in IDLE -> Clr_Ld only, no ClrA.
//      Reset_Load_Clear high during Busy -> no Clr_Ld.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the signed shift-add multiplier.
//   MULT_WIDTH   operand width used by both the sequencer and the datapath top
//   mult_state_t sequencer states
package mult_pkg;

  localparam int MULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLRA  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } mult_state_t;

endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-flop synchronizer for a raw asynchronous key level.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low clear of every stage
//   d      in  raw asynchronous input
//   q      out synchronized level, STAGES clocks behind d
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // New sample enters at bit 0; the oldest sample leaves at the top bit.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer: cycle sequencer for the 8-bit signed shift-add multiplier.
// Turns the Run and Reset_Load_Clear keys into one-cycle datapath strobes and
// runs a fixed 1 + 2*WIDTH cycle multiply.
// Ports:
//   Clk               in  system clock
//   Reset_n           in  asynchronous active-low reset
//   Run               in  raw key: start a multiply
//   Reset_Load_Clear  in  raw key: load B, clear A/X
//   M                 in  current multiplier LSB from the datapath
//   Clr_Ld            out load B, clear A and X
//   ClrA              out clear A and X, keep B
//   Add               out A/X <= A + SW
//   Sub               out A/X <= A - SW (sign-bit iteration)
//   Shift             out arithmetic right shift of X:A:B
//   Busy              out multiply in progress
//   Done              out result valid, held until Run is released
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH       = MULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Run,
  input  logic Reset_Load_Clear,
  input  logic M,
  output logic Clr_Ld,
  output logic ClrA,
  output logic Add,
  output logic Sub,
  output logic Shift,
  output logic Busy,
  output logic Done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic runs;
  logic rlc;

  mult_state_t       state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_run (
    .clk   (Clk),
    .rst_n (Reset_n),
    .d     (Run),
    .q     (runs)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_rlc (
    .clk   (Clk),
    .rst_n (Reset_n),
    .d     (Reset_Load_Clear),
    .q     (rlc)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // HOLD only leaves on Run low, so a held Run cannot restart the multiply.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (!rlc && runs) begin
          state_d = CLRA;
        end
      end
      CLRA: begin
        count_d = '0;
        state_d = ADD;
      end
      ADD: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        count_d = count_q + CNT_W'(1);
        state_d = (count_q == LAST) ? HOLD : ADD;
      end
      HOLD: begin
        if (!runs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // The last multiplier bit carries negative weight, so it subtracts.
  always_comb begin
    Clr_Ld = 1'b0;
    ClrA   = 1'b0;
    Add    = 1'b0;
    Sub    = 1'b0;
    Shift  = 1'b0;
    Busy   = 1'b0;
    Done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        Clr_Ld = rlc;
      end
      CLRA: begin
        ClrA = 1'b1;
        Busy = 1'b1;
      end
      ADD: begin
        Add  = M && (count_q != LAST);
        Sub  = M && (count_q == LAST);
        Busy = 1'b1;
      end
      SHIFT: begin
        Shift = 1'b1;
        Busy  = 1'b1;
      end
      HOLD: begin
        Done = 1'b1;
      end
      default: begin
        Busy = 1'b0;
      end
    endcase
  end

endmodule
